// File: rtl/ahb_master_engine_if.sv
// Local command/response port plus the AHB master bus signals, bundled for the engine.
interface ahb_master_engine_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [31:0]  cmd_addr;
  logic [2:0]   cmd_size;
  logic         cmd_burst4;
  logic [127:0] cmd_wdata;

  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_last;
  logic         rsp_err;

  logic         HBUSREQ;
  logic         HGRANT;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [3:0]   HPROT;
  logic         HMASTLOCK;
  logic [31:0]  HWDATA;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [31:0]  HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst4, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    output HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HGRANT, HREADY, HRESP, HRDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst4, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err,
    input  HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HGRANT, HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_master_engine.sv
// AHB initiator for SINGLE/INCR4 commands; rsp two cycles after the address phase, one per read beat.
// One command in flight (cmd_ready only in IDLE); retries, splits and grant loss resume as NONSEQ/INCR.
module ahb_master_engine (
  input logic clock,
  input logic reset,
  ahb_master_engine_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ARB = 2'd1, S_XFER = 2'd2, S_RESP2 = 2'd3;
  localparam logic [1:0] TR_IDLE = 2'b00, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;
  localparam logic [1:0] RS_OKAY = 2'b00, RS_ERROR = 2'b01;
  localparam logic [2:0] BU_SINGLE = 3'b000, BU_INCR = 3'b001, BU_INCR4 = 3'b011;

  logic [1:0]   state;
  logic         write_q;
  logic [2:0]   size_q;
  logic [127:0] wdata_q;
  logic [1:0]   last_beat;
  logic [2:0]   nxt_beat;
  logic [31:0]  nxt_addr;
  logic [1:0]   ap_beat;
  logic         dp_vld;
  logic [1:0]   dp_beat;
  logic [31:0]  dp_addr;
  logic         resumed_q;
  logic [1:0]   resp_q;
  logic [31:0]  incr;
  logic [2:0]   issue_burst;

  assign bus.HPROT     = 4'b0011;
  assign bus.HMASTLOCK = 1'b0;
  assign incr          = 32'd1 << size_q;

  // A resumed burst no longer has a fixed length, so it goes out as INCR or SINGLE.
  always_comb begin
    issue_burst = BU_SINGLE;
    if (!resumed_q)
      issue_burst = (last_beat != 2'd0) ? BU_INCR4 : BU_SINGLE;
    else if (nxt_beat < {1'b0, last_beat})
      issue_burst = BU_INCR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_last  <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.HBUSREQ   <= 1'b0;
      bus.HADDR     <= '0;
      bus.HTRANS    <= TR_IDLE;
      bus.HWRITE    <= 1'b0;
      bus.HSIZE     <= '0;
      bus.HBURST    <= BU_SINGLE;
      bus.HWDATA    <= '0;
      write_q       <= 1'b0;
      size_q        <= '0;
      wdata_q       <= '0;
      last_beat     <= '0;
      nxt_beat      <= '0;
      nxt_addr      <= '0;
      ap_beat       <= '0;
      dp_vld        <= 1'b0;
      dp_beat       <= '0;
      dp_addr       <= '0;
      resumed_q     <= 1'b0;
      resp_q        <= RS_OKAY;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_size > 3'd2) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_last  <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state         <= S_ARB;
              bus.cmd_ready <= 1'b0;
              bus.HBUSREQ   <= 1'b1;
              write_q       <= bus.cmd_write;
              size_q        <= bus.cmd_size;
              wdata_q       <= bus.cmd_wdata;
              last_beat     <= bus.cmd_burst4 ? 2'd3 : 2'd0;
              nxt_beat      <= '0;
              nxt_addr      <= bus.cmd_addr;
              dp_vld        <= 1'b0;
              resumed_q     <= 1'b0;
            end
          end
        end

        S_ARB: begin
          if (bus.HGRANT && bus.HREADY) begin
            state       <= S_XFER;
            bus.HTRANS  <= TR_NONSEQ;
            bus.HADDR   <= nxt_addr;
            bus.HBURST  <= issue_burst;
            bus.HWRITE  <= write_q;
            bus.HSIZE   <= size_q;
            ap_beat     <= nxt_beat[1:0];
            nxt_beat    <= nxt_beat + 3'd1;
            nxt_addr    <= nxt_addr + incr;
          end
        end

        S_XFER: begin
          if (!bus.HREADY) begin
            // First cycle of a two-cycle response: cancel whatever address is pipelined.
            if (dp_vld && bus.HRESP != RS_OKAY) begin
              state      <= S_RESP2;
              bus.HTRANS <= TR_IDLE;
              resp_q     <= bus.HRESP;
            end
          end else begin
            if (dp_vld && (!write_q || dp_beat == last_beat)) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= write_q ? 32'd0 : bus.HRDATA;
              bus.rsp_last  <= (dp_beat == last_beat);
              bus.rsp_err   <= 1'b0;
            end
            if (bus.HTRANS[1]) begin
              dp_vld  <= 1'b1;
              dp_beat <= ap_beat;
              dp_addr <= bus.HADDR;
              if (write_q)
                bus.HWDATA <= wdata_q[{ap_beat, 5'd0} +: 32];
              if (ap_beat == last_beat)
                bus.HBUSREQ <= 1'b0;
              if (ap_beat != last_beat && bus.HGRANT) begin
                bus.HTRANS <= TR_SEQ;
                bus.HADDR  <= nxt_addr;
                ap_beat    <= nxt_beat[1:0];
                nxt_beat   <= nxt_beat + 3'd1;
                nxt_addr   <= nxt_addr + incr;
              end else begin
                bus.HTRANS <= TR_IDLE;
              end
            end else begin
              // Bus idle and the last data phase drained: done, or grant was lost mid-burst.
              dp_vld <= 1'b0;
              if (dp_vld && dp_beat == last_beat) begin
                state         <= S_IDLE;
                bus.cmd_ready <= 1'b1;
              end else begin
                state       <= S_ARB;
                bus.HBUSREQ <= 1'b1;
                resumed_q   <= 1'b1;
              end
            end
          end
        end

        S_RESP2: begin
          if (bus.HREADY) begin
            dp_vld <= 1'b0;
            if (resp_q == RS_ERROR) begin
              state         <= S_IDLE;
              bus.cmd_ready <= 1'b1;
              bus.HBUSREQ   <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_last  <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state       <= S_ARB;
              bus.HBUSREQ <= 1'b1;
              nxt_beat    <= {1'b0, dp_beat};
              nxt_addr    <= dp_addr;
              resumed_q   <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_master_engine.sv
// Directed cycle-by-cycle bench for ahb_master_engine; the slave side is driven by hand.
module tb_ahb_master_engine;
  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  ahb_master_engine_if bus ();

  ahb_master_engine dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic b4, input logic [127:0] wd);
    chk("cmd_ready_before_issue", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = w;
    bus.cmd_addr   = a;
    bus.cmd_size   = s;
    bus.cmd_burst4 = b4;
    bus.cmd_wdata  = wd;
    tick();
    bus.cmd_valid  = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                         input logic l, input logic e);
    chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_rdata"}, bus.rsp_rdata, d);
      chk({tag, "_last"},  {31'd0, bus.rsp_last}, {31'd0, l});
      chk({tag, "_err"},   {31'd0, bus.rsp_err},  {31'd0, e});
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_size   = '0;
    bus.cmd_burst4 = 1'b0;
    bus.cmd_wdata  = '0;
    bus.HGRANT     = 1'b1;
    bus.HREADY     = 1'b1;
    bus.HRESP      = 2'b00;
    bus.HRDATA     = '0;
    tick();
    tick();
    chk("rst_htrans",  {30'd0, bus.HTRANS}, 32'd0);
    chk("rst_haddr",   bus.HADDR, 32'd0);
    chk("rst_hbusreq", {31'd0, bus.HBUSREQ}, 32'd0);
    chk("rst_hburst",  {29'd0, bus.HBURST}, 32'd0);
    chk("rst_hwdata",  bus.HWDATA, 32'd0);
    chk_rsp("rst_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("hprot", {28'd0, bus.HPROT}, 32'h3);

    // SINGLE write, no waits
    issue(1'b1, 32'h1000, 3'd2, 1'b0, {96'd0, 32'hDEADBEEF});
    chk("w1_c1_busreq", {31'd0, bus.HBUSREQ}, 32'd1);
    chk("w1_c1_ready",  {31'd0, bus.cmd_ready}, 32'd0);
    chk("w1_c1_htrans", {30'd0, bus.HTRANS}, 32'd0);
    tick();
    chk("w1_c2_htrans", {30'd0, bus.HTRANS}, 32'h2);
    chk("w1_c2_haddr",  bus.HADDR, 32'h1000);
    chk("w1_c2_hburst", {29'd0, bus.HBURST}, 32'd0);
    chk("w1_c2_hwrite", {31'd0, bus.HWRITE}, 32'd1);
    chk("w1_c2_hsize",  {29'd0, bus.HSIZE}, 32'd2);
    tick();
    chk("w1_c3_hwdata", bus.HWDATA, 32'hDEADBEEF);
    chk("w1_c3_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk("w1_c3_busreq", {31'd0, bus.HBUSREQ}, 32'd0);
    chk_rsp("w1_c3_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk_rsp("w1_c4_rsp", 1'b1, 32'd0, 1'b1, 1'b0);
    chk("w1_c4_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    chk_rsp("w1_c5_rsp", 1'b0, 32'd0, 1'b0, 1'b0);

    // INCR4 read, two wait states on beat 2
    issue(1'b0, 32'h2000, 3'd2, 1'b1, '0);
    tick();
    chk("r2_c2_htrans", {30'd0, bus.HTRANS}, 32'h2);
    chk("r2_c2_haddr",  bus.HADDR, 32'h2000);
    chk("r2_c2_hburst", {29'd0, bus.HBURST}, 32'h3);
    tick();
    chk("r2_c3_htrans", {30'd0, bus.HTRANS}, 32'h3);
    chk("r2_c3_haddr",  bus.HADDR, 32'h2004);
    bus.HRDATA = 32'hA0A0_0000;
    tick();
    chk("r2_c4_haddr",  bus.HADDR, 32'h2008);
    chk("r2_c4_htrans", {30'd0, bus.HTRANS}, 32'h3);
    chk_rsp("r2_c4_rsp", 1'b1, 32'hA0A0_0000, 1'b0, 1'b0);
    bus.HREADY = 1'b0;
    bus.HRDATA = 32'h0BAD_0BAD;
    tick();
    chk("r2_c5_haddr", bus.HADDR, 32'h2008);
    chk_rsp("r2_c5_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("r2_c6_haddr", bus.HADDR, 32'h2008);
    chk_rsp("r2_c6_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    bus.HREADY = 1'b1;
    bus.HRDATA = 32'hA0A0_0001;
    tick();
    chk("r2_c7_haddr", bus.HADDR, 32'h200C);
    chk_rsp("r2_c7_rsp", 1'b1, 32'hA0A0_0001, 1'b0, 1'b0);
    bus.HRDATA = 32'hA0A0_0002;
    tick();
    chk("r2_c8_htrans",  {30'd0, bus.HTRANS}, 32'd0);
    chk("r2_c8_busreq",  {31'd0, bus.HBUSREQ}, 32'd0);
    chk_rsp("r2_c8_rsp", 1'b1, 32'hA0A0_0002, 1'b0, 1'b0);
    bus.HRDATA = 32'hA0A0_0003;
    tick();
    chk_rsp("r2_c9_rsp", 1'b1, 32'hA0A0_0003, 1'b1, 1'b0);
    tick();
    chk_rsp("r2_c10_rsp", 1'b0, 32'd0, 1'b0, 1'b0);

    // INCR4 write, ERROR on beat 3
    issue(1'b1, 32'h3000, 3'd2, 1'b1, 128'h44444444_33333333_22222222_11111111);
    tick();
    chk("e3_c2_htrans", {30'd0, bus.HTRANS}, 32'h2);
    chk("e3_c2_haddr",  bus.HADDR, 32'h3000);
    tick();
    chk("e3_c3_hwdata", bus.HWDATA, 32'h11111111);
    chk("e3_c3_haddr",  bus.HADDR, 32'h3004);
    tick();
    chk("e3_c4_hwdata", bus.HWDATA, 32'h22222222);
    chk("e3_c4_haddr",  bus.HADDR, 32'h3008);
    tick();
    chk("e3_c5_hwdata", bus.HWDATA, 32'h33333333);
    chk("e3_c5_htrans", {30'd0, bus.HTRANS}, 32'h3);
    chk("e3_c5_haddr",  bus.HADDR, 32'h300C);
    bus.HREADY = 1'b0;
    bus.HRESP  = 2'b01;
    tick();
    chk("e3_c6_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk_rsp("e3_c6_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    bus.HREADY = 1'b1;
    tick();
    chk_rsp("e3_c7_rsp", 1'b1, 32'd0, 1'b1, 1'b1);
    chk("e3_c7_busreq", {31'd0, bus.HBUSREQ}, 32'd0);
    chk("e3_c7_htrans", {30'd0, bus.HTRANS}, 32'd0);
    bus.HRESP = 2'b00;
    tick();
    chk("e3_c8_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk_rsp("e3_c8_rsp", 1'b0, 32'd0, 1'b0, 1'b0);

    // INCR4 read, RETRY on beat 2
    issue(1'b0, 32'h4000, 3'd2, 1'b1, '0);
    tick();
    chk("t4_c2_haddr", bus.HADDR, 32'h4000);
    tick();
    chk("t4_c3_haddr", bus.HADDR, 32'h4004);
    bus.HRDATA = 32'hB000_0000;
    tick();
    chk_rsp("t4_c4_rsp", 1'b1, 32'hB000_0000, 1'b0, 1'b0);
    chk("t4_c4_haddr", bus.HADDR, 32'h4008);
    bus.HREADY = 1'b0;
    bus.HRESP  = 2'b10;
    tick();
    chk("t4_c5_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk_rsp("t4_c5_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    bus.HREADY = 1'b1;
    tick();
    chk("t4_c6_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk("t4_c6_busreq", {31'd0, bus.HBUSREQ}, 32'd1);
    chk_rsp("t4_c6_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    bus.HRESP = 2'b00;
    tick();
    chk("t4_c7_htrans", {30'd0, bus.HTRANS}, 32'h2);
    chk("t4_c7_haddr",  bus.HADDR, 32'h4004);
    chk("t4_c7_hburst", {29'd0, bus.HBURST}, 32'h1);
    chk_rsp("t4_c7_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("t4_c8_htrans", {30'd0, bus.HTRANS}, 32'h3);
    chk("t4_c8_haddr",  bus.HADDR, 32'h4008);
    bus.HRDATA = 32'hB000_0001;
    tick();
    chk("t4_c9_haddr", bus.HADDR, 32'h400C);
    chk_rsp("t4_c9_rsp", 1'b1, 32'hB000_0001, 1'b0, 1'b0);
    bus.HRDATA = 32'hB000_0002;
    tick();
    chk_rsp("t4_c10_rsp", 1'b1, 32'hB000_0002, 1'b0, 1'b0);
    bus.HRDATA = 32'hB000_0003;
    tick();
    chk_rsp("t4_c11_rsp", 1'b1, 32'hB000_0003, 1'b1, 1'b0);

    // INCR4 read, grant lost after beat 1
    issue(1'b0, 32'h5000, 3'd2, 1'b1, '0);
    tick();
    chk("g5_c2_htrans", {30'd0, bus.HTRANS}, 32'h2);
    chk("g5_c2_haddr",  bus.HADDR, 32'h5000);
    bus.HGRANT = 1'b0;
    tick();
    chk("g5_c3_htrans", {30'd0, bus.HTRANS}, 32'd0);
    bus.HRDATA = 32'hC000_0000;
    tick();
    chk_rsp("g5_c4_rsp", 1'b1, 32'hC000_0000, 1'b0, 1'b0);
    chk("g5_c4_busreq", {31'd0, bus.HBUSREQ}, 32'd1);
    chk("g5_c4_htrans", {30'd0, bus.HTRANS}, 32'd0);
    tick();
    chk("g5_c5_htrans", {30'd0, bus.HTRANS}, 32'd0);
    bus.HGRANT = 1'b1;
    tick();
    chk("g5_c6_htrans", {30'd0, bus.HTRANS}, 32'h2);
    chk("g5_c6_haddr",  bus.HADDR, 32'h5004);
    chk("g5_c6_hburst", {29'd0, bus.HBURST}, 32'h1);
    tick();
    chk("g5_c7_htrans", {30'd0, bus.HTRANS}, 32'h3);
    chk("g5_c7_haddr",  bus.HADDR, 32'h5008);
    bus.HRDATA = 32'hC000_0001;
    tick();
    chk("g5_c8_haddr", bus.HADDR, 32'h500C);
    chk_rsp("g5_c8_rsp", 1'b1, 32'hC000_0001, 1'b0, 1'b0);
    bus.HRDATA = 32'hC000_0002;
    tick();
    chk_rsp("g5_c9_rsp", 1'b1, 32'hC000_0002, 1'b0, 1'b0);
    bus.HRDATA = 32'hC000_0003;
    tick();
    chk_rsp("g5_c10_rsp", 1'b1, 32'hC000_0003, 1'b1, 1'b0);

    // Illegal size: immediate error, no bus activity
    issue(1'b0, 32'h6000, 3'd3, 1'b0, '0);
    chk_rsp("s6_c1_rsp", 1'b1, 32'd0, 1'b1, 1'b1);
    chk("s6_c1_busreq", {31'd0, bus.HBUSREQ}, 32'd0);
    chk("s6_c1_htrans", {30'd0, bus.HTRANS}, 32'd0);
    chk("s6_c1_ready",  {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    chk_rsp("s6_c2_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    chk("s6_c2_htrans", {30'd0, bus.HTRANS}, 32'd0);

    // Reset in the middle of an INCR4 read
    issue(1'b0, 32'h7000, 3'd2, 1'b1, '0);
    tick();
    chk("x7_c2_htrans", {30'd0, bus.HTRANS}, 32'h2);
    bus.HRDATA = 32'hD000_0000;
    tick();
    chk("x7_c3_htrans", {30'd0, bus.HTRANS}, 32'h3);
    reset = 1'b1;
    tick();
    chk("x7_c4_htrans",  {30'd0, bus.HTRANS}, 32'd0);
    chk("x7_c4_busreq",  {31'd0, bus.HBUSREQ}, 32'd0);
    chk_rsp("x7_c4_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_rsp("x7_c5_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    chk("x7_c5_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    chk_rsp("x7_c6_rsp", 1'b0, 32'd0, 1'b0, 1'b0);
    chk("x7_c6_htrans", {30'd0, bus.HTRANS}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
